// File: rtl/dataframe_capture_axi_if.sv
// AXI4-Lite bus bundle for the uplink frame store.
// The slave modport is the register/readout side and the master modport is the host side.
interface dataframe_capture_axi_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   awaddr;
  logic [2:0]          awprot;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic [2:0]          arprot;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/dataframe_capture_axi.sv
// Uplink frame store: captures lpGBT user-data frames into a DEPTH-deep buffer
// (one-shot or ring, optional masked trigger) and exposes them to the host over
// AXI4-Lite using an indirect frame-select register and per-word windows.
module dataframe_capture_axi #(
  parameter int FRAME_W            = 234,
  parameter int DEPTH              = 64,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 8
) (
  input  logic                       S_AXI_ACLK,
  input  logic                       S_AXI_ARESETN,
  input  logic [FRAME_W-1:0]         frame_data_i,
  input  logic                       frame_valid_i,
  input  logic                       link_ready_i,
  dataframe_capture_axi_if.slave     s_axi,
  output logic                       capture_done_o
);
  localparam int AW    = C_S_AXI_ADDR_WIDTH;
  localparam int DW    = C_S_AXI_DATA_WIDTH;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int WORDS = (FRAME_W + 31) / 32;
  localparam int PAD_W = WORDS * 32;

  localparam logic [AW-3:0] W_CTRL   = (AW-2)'(0);
  localparam logic [AW-3:0] W_STATUS = (AW-2)'(1);
  localparam logic [AW-3:0] W_MASK   = (AW-2)'(2);
  localparam logic [AW-3:0] W_VALUE  = (AW-2)'(3);
  localparam logic [AW-3:0] W_SEL    = (AW-2)'(4);
  localparam logic [AW-3:0] W_PARAM  = (AW-2)'(5);
  localparam logic [AW-3:0] W_FRAME0 = (AW-2)'(16);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_TRIG = 2'd1,
    ST_CAPTURE   = 2'd2,
    ST_DONE      = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic               mode_q, trig_en_q;
  logic [DW-1:0]      trig_mask_q, trig_value_q;
  logic [PTR_W-1:0]   frame_sel_q, wr_ptr_q, phys_idx;
  logic [CNT_W-1:0]   count_q;
  logic               wrapped_q, link_lost_q;
  logic               store, arm_go;

  logic [FRAME_W-1:0] mem [DEPTH];
  logic [FRAME_W-1:0] rd_frame_q;

  logic               aw_ready_q, bvalid_q, ar_ready_q, rvalid_q;
  logic               rd_s1_q, rd_s2_q, sel_ok_q;
  logic [AW-1:0]      rd_addr_q;
  logic [DW-1:0]      reg_rd_q, reg_rd_val, rdata_q, sel_merged;
  logic [PAD_W-1:0]   rd_shifted;

  logic               wr_hs, rd_hs, ctrl_wr, qual, trig_hit;
  logic               arm_p, stop_p, clear_p, trig_en_eff;
  logic [AW-3:0]      wr_widx, rd_widx, rd_fidx;
  logic               rd_is_frame;
  logic               unused_bits;

  // Byte-lane merge used by every writable register
  function automatic logic [DW-1:0] merge_bytes(input logic [DW-1:0] old_v,
                                                input logic [DW-1:0] new_v,
                                                input logic [DW/8-1:0] strb);
    logic [DW-1:0] res;
    for (int i = 0; i < DW/8; i++)
      res[8*i +: 8] = strb[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
    return res;
  endfunction

  assign wr_hs       = aw_ready_q && s_axi.awvalid && s_axi.wvalid;
  assign rd_hs       = ar_ready_q && s_axi.arvalid;
  assign wr_widx     = s_axi.awaddr[AW-1:2];
  assign rd_widx     = rd_addr_q[AW-1:2];
  assign rd_fidx     = rd_widx - W_FRAME0;
  assign rd_is_frame = (rd_widx >= W_FRAME0) && (rd_fidx < (AW-2)'(WORDS));
  assign ctrl_wr     = wr_hs && (wr_widx == W_CTRL);
  assign clear_p     = ctrl_wr && s_axi.wstrb[0] && s_axi.wdata[2];
  assign arm_p       = ctrl_wr && s_axi.wstrb[0] && s_axi.wdata[0] && !clear_p;
  assign stop_p      = ctrl_wr && s_axi.wstrb[0] && s_axi.wdata[1] && !s_axi.wdata[0] && !clear_p;
  assign trig_en_eff = (ctrl_wr && s_axi.wstrb[1]) ? s_axi.wdata[9] : trig_en_q;
  assign qual        = frame_valid_i && link_ready_i;
  assign trig_hit    = ((frame_data_i[31:0] ^ trig_value_q) & trig_mask_q) == '0;
  assign phys_idx    = (wrapped_q ? wr_ptr_q : '0) + frame_sel_q;
  assign sel_merged  = merge_bytes(DW'(frame_sel_q), s_axi.wdata, s_axi.wstrb);
  assign rd_shifted  = PAD_W'(rd_frame_q) >> {rd_fidx, 5'd0};

  assign s_axi.awready = aw_ready_q;
  assign s_axi.wready  = aw_ready_q;
  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.bresp   = 2'b00;
  assign s_axi.arready = ar_ready_q;
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rdata   = rdata_q;
  assign s_axi.rresp   = 2'b00;
  assign capture_done_o = (state_q == ST_DONE);

  assign unused_bits = ^{s_axi.awprot, s_axi.arprot, s_axi.awaddr[1:0],
                         rd_addr_q[1:0], sel_merged[DW-1:PTR_W]};

  // Capture state register
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) state_q <= ST_IDLE;
    else                state_q <= state_d;
  end

  // Next-state and store decision; CLEAR overrides everything else
  always_comb begin
    state_d = state_q;
    store   = 1'b0;
    arm_go  = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (arm_p) begin
          arm_go  = 1'b1;
          state_d = trig_en_eff ? ST_WAIT_TRIG : ST_CAPTURE;
        end
      end
      ST_WAIT_TRIG: begin
        if (qual && trig_hit) begin
          store   = 1'b1;
          state_d = ST_CAPTURE;
        end
        if (stop_p) state_d = ST_DONE;
      end
      ST_CAPTURE: begin
        if (qual) begin
          store = 1'b1;
          if (!mode_q && count_q == CNT_W'(DEPTH-1)) state_d = ST_DONE;
        end
        if (stop_p) state_d = ST_DONE;
      end
      default: ;
    endcase
    if (clear_p) begin
      state_d = ST_IDLE;
      store   = 1'b0;
      arm_go  = 1'b0;
    end
  end

  // Write pointer, fill count, wrap flag and sticky link-loss flag
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      wr_ptr_q    <= '0;
      count_q     <= '0;
      wrapped_q   <= 1'b0;
      link_lost_q <= 1'b0;
    end else if (clear_p) begin
      wr_ptr_q  <= '0;
      count_q   <= '0;
      wrapped_q <= 1'b0;
    end else if (arm_go) begin
      wr_ptr_q    <= '0;
      count_q     <= '0;
      wrapped_q   <= 1'b0;
      link_lost_q <= 1'b0;
    end else begin
      if (store) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
        if (count_q != CNT_W'(DEPTH)) count_q <= count_q + CNT_W'(1);
        if (mode_q && wr_ptr_q == PTR_W'(DEPTH-1)) wrapped_q <= 1'b1;
      end
      if ((state_q == ST_WAIT_TRIG || state_q == ST_CAPTURE) && !link_ready_i)
        link_lost_q <= 1'b1;
    end
  end

  // Frame buffer: write on store, registered read of the selected logical frame
  always_ff @(posedge S_AXI_ACLK) begin
    if (store) mem[wr_ptr_q] <= frame_data_i;
    rd_frame_q <= mem[phys_idx];
  end

  // Host-writable configuration registers with byte strobes
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      mode_q       <= 1'b0;
      trig_en_q    <= 1'b0;
      trig_mask_q  <= '0;
      trig_value_q <= '0;
      frame_sel_q  <= '0;
    end else if (wr_hs) begin
      unique case (wr_widx)
        W_CTRL: begin
          if (s_axi.wstrb[1]) begin
            mode_q    <= s_axi.wdata[8];
            trig_en_q <= s_axi.wdata[9];
          end
        end
        W_MASK:  trig_mask_q  <= merge_bytes(trig_mask_q, s_axi.wdata, s_axi.wstrb);
        W_VALUE: trig_value_q <= merge_bytes(trig_value_q, s_axi.wdata, s_axi.wstrb);
        W_SEL:   frame_sel_q  <= sel_merged[PTR_W-1:0];
        default: ;
      endcase
    end
  end

  // Write channel: single-cycle AW/W ready pulse, response held until accepted
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      aw_ready_q <= 1'b0;
      bvalid_q   <= 1'b0;
    end else begin
      aw_ready_q <= !aw_ready_q && s_axi.awvalid && s_axi.wvalid && !bvalid_q;
      if (wr_hs)             bvalid_q <= 1'b1;
      else if (s_axi.bready) bvalid_q <= 1'b0;
    end
  end

  // Register-side read value, decoded from the latched read address
  always_comb begin
    reg_rd_val = '0;
    unique case (rd_widx)
      W_CTRL:   reg_rd_val = {22'd0, trig_en_q, mode_q, 8'd0};
      W_STATUS: reg_rd_val = {16'(count_q), 12'd0, link_lost_q, wrapped_q, state_q};
      W_MASK:   reg_rd_val = trig_mask_q;
      W_VALUE:  reg_rd_val = trig_value_q;
      W_SEL:    reg_rd_val = DW'(frame_sel_q);
      W_PARAM:  reg_rd_val = {16'(FRAME_W), 16'(DEPTH)};
      default:  reg_rd_val = '0;
    endcase
  end

  // Read channel: address accept, one RAM stage, then data held until accepted
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      ar_ready_q <= 1'b0;
      rd_s1_q    <= 1'b0;
      rd_s2_q    <= 1'b0;
      rd_addr_q  <= '0;
      reg_rd_q   <= '0;
      sel_ok_q   <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
    end else begin
      ar_ready_q <= !ar_ready_q && s_axi.arvalid && !rvalid_q && !rd_s1_q && !rd_s2_q;
      rd_s1_q    <= rd_hs;
      rd_s2_q    <= rd_s1_q;
      if (rd_hs) rd_addr_q <= s_axi.araddr;
      if (rd_s1_q) begin
        reg_rd_q <= reg_rd_val;
        sel_ok_q <= {1'b0, frame_sel_q} < count_q;
      end
      if (rd_s2_q) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_is_frame ? (sel_ok_q ? rd_shifted[31:0] : '0) : reg_rd_q;
      end else if (s_axi.rready) begin
        rvalid_q <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_dataframe_capture_axi.sv
// Self-checking bench for the uplink frame store: random frame payloads are
// checked against a queue-based model of the stored frames and status.
module tb_dataframe_capture_axi;
  localparam int FRAME_W = 234;
  localparam int DEPTH   = 64;
  localparam int WORDS   = 8;
  localparam int AW      = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [FRAME_W-1:0] frame_data;
  logic frame_valid, link_ready, capture_done;

  always #5 clk = ~clk;

  dataframe_capture_axi_if #(.ADDR_W(AW), .DATA_W(32)) axi ();

  dataframe_capture_axi #(
    .FRAME_W(FRAME_W), .DEPTH(DEPTH), .C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(AW)
  ) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n), .frame_data_i(frame_data),
    .frame_valid_i(frame_valid), .link_ready_i(link_ready), .s_axi(axi),
    .capture_done_o(capture_done)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: logical frame list, oldest first
  int                 m_state;
  bit                 m_mode, m_trig_en, m_link_lost, m_wrapped;
  int                 m_stores;
  logic [31:0]        m_mask, m_value;
  logic [FRAME_W-1:0] m_frames[$];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [FRAME_W-1:0] make_frame(input logic [31:0] low);
    logic [511:0] t;
    for (int i = 0; i < 16; i++) t[32*i +: 32] = $urandom;
    t[31:0] = low;
    return t[FRAME_W-1:0];
  endfunction

  function automatic logic [31:0] exp_status();
    return {16'(m_frames.size()), 12'h000, m_link_lost, m_wrapped, 2'(m_state)};
  endfunction

  function automatic logic [31:0] exp_word(input int sel, input int k);
    logic [511:0] t;
    t = '0;
    if (sel < m_frames.size()) t[FRAME_W-1:0] = m_frames[sel];
    return t[32*k +: 32];
  endfunction

  task automatic model_reset();
    m_state = 0; m_mode = 0; m_trig_en = 0; m_link_lost = 0; m_wrapped = 0;
    m_stores = 0; m_mask = '0; m_value = '0;
    m_frames.delete();
  endtask

  // One frame cycle: drive inputs, advance the model, move to next negedge
  task automatic applyStimulus(input bit v, input bit r, input logic [FRAME_W-1:0] d);
    frame_valid = v; link_ready = r; frame_data = d;
    if ((m_state == 1 || m_state == 2) && !r) m_link_lost = 1;
    if (m_state == 1 && v && r && ((d[31:0] ^ m_value) & m_mask) == 0) begin
      m_frames.push_back(d); m_stores++; m_state = 2;
    end else if (m_state == 2 && v && r) begin
      m_frames.push_back(d); m_stores++;
      if (m_frames.size() > DEPTH) void'(m_frames.pop_front());
      if (m_mode && m_stores >= DEPTH) m_wrapped = 1;
      if (!m_mode && m_frames.size() == DEPTH) m_state = 3;
    end
    @(negedge clk);
    checkOutput("capture_done", {31'd0, capture_done}, {31'd0, m_state == 3});
    frame_valid = 0; link_ready = 1;
  endtask

  task automatic axi_write(input logic [AW-1:0] addr, input logic [31:0] data, input logic [3:0] strb);
    int n;
    axi.awaddr = addr; axi.wdata = data; axi.wstrb = strb;
    axi.awvalid = 1; axi.wvalid = 1;
    n = 0;
    do begin @(negedge clk); n++; end while (!axi.awready && n < 20);
    checkOutput("awready", {31'd0, axi.awready}, 32'd1);
    @(negedge clk);
    axi.awvalid = 0; axi.wvalid = 0;
    checkOutput("bvalid", {31'd0, axi.bvalid}, 32'd1);
    checkOutput("bresp", {30'd0, axi.bresp}, 32'd0);
    axi.bready = 1;
    @(negedge clk);
    axi.bready = 0;
  endtask

  task automatic axi_read(input logic [AW-1:0] addr, output logic [31:0] data,
                          output logic [1:0] resp, output int lat);
    int n;
    axi.araddr = addr; axi.arvalid = 1;
    n = 0;
    do begin @(negedge clk); n++; end while (!axi.arready && n < 20);
    checkOutput("arready", {31'd0, axi.arready}, 32'd1);
    @(negedge clk);
    axi.arvalid = 0;
    lat = 1;
    while (!axi.rvalid && lat < 20) begin @(negedge clk); lat++; end
    data = axi.rdata; resp = axi.rresp;
    axi.rready = 1;
    @(negedge clk);
    axi.rready = 0;
  endtask

  task automatic read_check(input string tag, input logic [AW-1:0] addr, input logic [31:0] exp);
    logic [31:0] d; logic [1:0] r; int lat;
    axi_read(addr, d, r, lat);
    checkOutput(tag, d, exp);
    checkOutput({tag, "_rresp"}, {30'd0, r}, 32'd0);
  endtask

  task automatic ctrl_write(input logic [31:0] d);
    axi_write(8'h00, d, 4'hF);
    m_mode = d[8]; m_trig_en = d[9];
    if (d[2]) begin
      m_state = 0; m_frames.delete(); m_stores = 0; m_wrapped = 0;
    end else if (d[0]) begin
      if (m_state == 0 || m_state == 3) begin
        m_frames.delete(); m_stores = 0; m_wrapped = 0; m_link_lost = 0;
        m_state = m_trig_en ? 1 : 2;
      end
    end else if (d[1]) begin
      if (m_state == 1 || m_state == 2) m_state = 3;
    end
  endtask

  task automatic check_word(input string tag, input int sel, input int k);
    axi_write(8'h10, 32'(sel), 4'hF);
    read_check(tag, AW'(64 + 4*k), exp_word(sel, k));
  endtask

  task automatic random_readback(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      int s, k;
      s = $urandom_range(0, DEPTH-1);
      k = $urandom_range(0, WORDS-1);
      check_word(tag, s, k);
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] d; logic [1:0] r; int lat, n;
    axi.awaddr = '0; axi.awprot = '0; axi.awvalid = 0; axi.wdata = '0; axi.wstrb = '0;
    axi.wvalid = 0; axi.bready = 0; axi.araddr = '0; axi.arprot = '0; axi.arvalid = 0;
    axi.rready = 0;
    frame_valid = 0; link_ready = 1; frame_data = '0;
    model_reset();

    // Reset values
    #12;
    checkOutput("rst_done", {31'd0, capture_done}, 32'd0);
    checkOutput("rst_handshake", {28'd0, axi.awready, axi.wready, axi.arready, axi.bvalid}, 32'd0);
    checkOutput("rst_rvalid_rdata", {31'd0, axi.rvalid} | axi.rdata, 32'd0);
    @(negedge clk); rst_n = 1; @(negedge clk);
    read_check("status_reset", 8'h04, exp_status());
    read_check("ctrl_reset", 8'h00, 32'h0);
    read_check("param", 8'h14, 32'h00EA0040);
    axi_read(8'h30, d, r, lat);
    checkOutput("unmapped", d, 32'h0);
    checkOutput("unmapped_rresp", {30'd0, r}, 32'd0);
    checkOutput("read_latency", 32'(lat), 32'd3);

    // One-shot, no trigger, 70 frames
    ctrl_write(32'h001);
    for (int i = 0; i < 70; i++) applyStimulus(1, 1, make_frame(32'(i)));
    read_check("oneshot_status", 8'h04, exp_status());
    read_check("oneshot_status_c", 8'h04, 32'h00400003);
    check_word("oneshot_sel10_w0", 10, 0);
    read_check("oneshot_sel10_w0_c", 8'h40, 32'd10);
    check_word("oneshot_sel10_w7", 10, 7);
    axi_read(8'h5C, d, r, lat);
    checkOutput("oneshot_w7_upper", d >> 10, 32'd0);
    random_readback("oneshot_rand", 6);

    // Masked trigger
    axi_write(8'h08, 32'hFF, 4'hF); m_mask = 32'hFF;
    axi_write(8'h0C, 32'h5A, 4'hF); m_value = 32'h5A;
    ctrl_write(32'h201);
    read_check("trig_wait_status", 8'h04, exp_status());
    for (int i = 0; i < 128; i++) applyStimulus(1, 1, make_frame(32'(i)));
    ctrl_write(32'h202);
    read_check("trig_status", 8'h04, exp_status());
    read_check("trig_status_c", 8'h04, 32'h00260003);
    check_word("trig_sel0", 0, 0);
    read_check("trig_sel0_c", 8'h40, 32'h5A);
    check_word("trig_sel1", 1, 0);
    read_check("trig_sel1_c", 8'h40, 32'h5B);
    check_word("trig_sel_beyond", 40, 3);
    read_check("trig_sel_beyond_c", 8'h4C, 32'h0);
    random_readback("trig_rand", 6);

    // Link loss during capture
    ctrl_write(32'h001);
    for (int i = 0; i < 5; i++) applyStimulus(1, 1, make_frame(32'(200 + i)));
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, make_frame(32'(205 + i)));
    for (int i = 0; i < 2; i++) applyStimulus(1, 1, make_frame(32'(208 + i)));
    ctrl_write(32'h002);
    read_check("link_status", 8'h04, exp_status());
    read_check("link_status_c", 8'h04, 32'h0007000B);
    check_word("link_sel5", 5, 0);
    read_check("link_sel5_c", 8'h40, 32'd208);

    // Ring mode with random idle gaps
    ctrl_write(32'h101);
    n = 0;
    while (n < 100) begin
      if ($urandom_range(0, 3) == 0) applyStimulus(0, 1, make_frame($urandom));
      else begin applyStimulus(1, 1, make_frame(32'(n))); n++; end
    end
    ctrl_write(32'h102);
    read_check("ring_status", 8'h04, exp_status());
    read_check("ring_status_c", 8'h04, 32'h00400007);
    check_word("ring_sel0", 0, 0);
    read_check("ring_sel0_c", 8'h40, 32'd36);
    check_word("ring_sel63", 63, 0);
    read_check("ring_sel63_c", 8'h40, 32'd99);
    random_readback("ring_rand", 8);

    // CLEAR wins over ARM and STOP in the same write
    ctrl_write(32'h001);
    for (int i = 0; i < 5; i++) applyStimulus(1, 1, make_frame($urandom));
    read_check("clear_pre_status", 8'h04, 32'h00050002);
    ctrl_write(32'h007);
    read_check("clear_status", 8'h04, exp_status());
    read_check("clear_status_c", 8'h04, 32'h0);
    read_check("clear_ctrl", 8'h00, 32'h0);
    axi_write(8'h08, 32'hFFFF_FFFF, 4'b0101); m_mask = 32'h00FF00FF;
    read_check("wstrb_mask", 8'h08, m_mask);

    // Back-pressure on B channel blocks a second write
    axi.awaddr = 8'h0C; axi.wdata = 32'h12345678; axi.wstrb = 4'hF;
    axi.awvalid = 1; axi.wvalid = 1;
    n = 0;
    do begin @(negedge clk); n++; end while (!axi.awready && n < 20);
    @(negedge clk);
    axi.awaddr = 8'h10; axi.wdata = 32'd3;
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_bvalid", {31'd0, axi.bvalid}, 32'd1);
      checkOutput("bp_awready", {31'd0, axi.awready}, 32'd0);
      @(negedge clk);
    end
    axi.bready = 1; @(negedge clk); axi.bready = 0;
    n = 0;
    while (!axi.awready && n < 20) begin @(negedge clk); n++; end
    checkOutput("bp_second_awready", {31'd0, axi.awready}, 32'd1);
    @(negedge clk);
    axi.awvalid = 0; axi.wvalid = 0;
    axi.bready = 1; @(negedge clk); axi.bready = 0;
    read_check("bp_value", 8'h0C, 32'h12345678);
    read_check("bp_sel", 8'h10, 32'd3);

    // Asynchronous reset in the middle of a capture
    ctrl_write(32'h001);
    for (int i = 0; i < 5; i++) applyStimulus(1, 1, make_frame($urandom));
    read_check("rst_pre_status", 8'h04, exp_status());
    axi.awaddr = 8'h08; axi.wdata = 32'h1; axi.wstrb = 4'hF; axi.awvalid = 1; axi.wvalid = 1;
    axi.araddr = 8'h04; axi.arvalid = 1;
    n = 0;
    while (!(axi.bvalid && axi.rvalid) && n < 20) begin
      @(negedge clk); n++;
      if (axi.bvalid) begin axi.awvalid = 0; axi.wvalid = 0; end
      if (axi.rvalid) axi.arvalid = 0;
    end
    checkOutput("rst_pre_b_r", {30'd0, axi.bvalid, axi.rvalid}, 32'd3);
    axi.awvalid = 0; axi.wvalid = 0; axi.arvalid = 0;
    #2 rst_n = 0;
    #1;
    checkOutput("async_done", {31'd0, capture_done}, 32'd0);
    checkOutput("async_bvalid", {31'd0, axi.bvalid}, 32'd0);
    checkOutput("async_rvalid", {31'd0, axi.rvalid}, 32'd0);
    @(negedge clk); rst_n = 1; model_reset(); @(negedge clk);
    read_check("post_rst_status", 8'h04, exp_status());
    read_check("post_rst_mask", 8'h08, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
